// File: rtl/vending_machine_core.sv
// Coin-operated vending controller: $4 item, accepts $1/$2/$5, returns change.
// Latency: one cycle from coin edge to registered dispense/change outputs.
// No backpressure: every single-coin edge is accepted; multi-coin edges are dropped.
module vending_machine_core (
  input  logic       clk,
  input  logic       reset,
  input  logic       one,
  input  logic       two,
  input  logic       five,
  output logic [2:0] cs,
  output logic [2:0] ns,
  output logic       d,
  output logic [2:0] r
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3
  } state_t;

  localparam logic [3:0] PRICE = 4'd4;

  state_t     state;
  state_t     next_state;
  logic [3:0] coin_val;
  logic [3:0] sum;
  logic [3:0] change;
  logic       single_coin;
  logic       legal;
  logic       buy;

  // Decode the coin inputs, accumulate credit, and pick the next credit level.
  always_comb begin
    coin_val = 4'd0;
    case ({one, two, five})
      3'b100:  coin_val = 4'd1;
      3'b010:  coin_val = 4'd2;
      3'b001:  coin_val = 4'd5;
      default: coin_val = 4'd0;  // idle, or several coins at once: ignored
    endcase
    single_coin = (coin_val != 4'd0);
    legal       = (state <= S3);
    sum         = {1'b0, state} + coin_val;
    change      = sum - PRICE;
    buy         = !reset && legal && single_coin && (sum >= PRICE);

    next_state = state;
    if (reset || !legal) begin
      // Reset and corrupted state codes both collapse to zero credit,
      // discarding whatever coin is offered on this edge.
      next_state = S0;
    end else if (single_coin) begin
      next_state = (sum >= PRICE) ? S0 : state_t'(sum[2:0]);
    end
  end

  // Credit register plus one-cycle dispense pulse and change value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      d     <= 1'b0;
      r     <= 3'd0;
    end else begin
      state <= next_state;
      d     <= buy;
      r     <= buy ? change[2:0] : 3'd0;
    end
  end

  assign cs = state;
  assign ns = next_state;

endmodule

// File: tb/tb_vending_machine_core.sv
// Bench for vending_machine_core: directed vector table, then random coins vs a credit model.
// Inputs driven on falling edges; ns checked before the rising edge, registers #1 after it.
// Every wait is a fixed clock count, so the run always terminates.
module tb_vending_machine_core;

  logic       clk = 1'b0;
  logic       reset, one, two, five;
  logic [2:0] cs, ns, r;
  logic       d;

  int total = 0;
  int bad   = 0;

  vending_machine_core dut (
    .clk  (clk),
    .reset(reset),
    .one  (one),
    .two  (two),
    .five (five),
    .cs   (cs),
    .ns   (ns),
    .d    (d),
    .r    (r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       c1;
    logic       c2;
    logic       c5;
    int         exp_cs;
    int         exp_d;
    int         exp_r;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: credit in dollars, plus the last dispense/change.
  int m_credit;
  int m_d;
  int m_r;

  task automatic add(input logic rst, input logic c1, input logic c2, input logic c5,
                     input int ecs, input int ed, input int er, input string tag);
    vec_t v;
    v.rst = rst; v.c1 = c1; v.c2 = c2; v.c5 = c5;
    v.exp_cs = ecs; v.exp_d = ed; v.exp_r = er; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model step computed directly from the pricing rules.
  task automatic model_step(input logic rst, input logic c1, input logic c2, input logic c5);
    int n;
    int v;
    int s;
    n = int'(c1) + int'(c2) + int'(c5);
    m_d = 0;
    m_r = 0;
    if (rst) begin
      m_credit = 0;
    end else if (n == 1) begin
      v = c1 ? 1 : (c2 ? 2 : 5);
      s = m_credit + v;
      if (s >= 4) begin
        m_d = 1;
        m_r = s - 4;
        m_credit = 0;
      end else begin
        m_credit = s;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic c1, input logic c2, input logic c5);
    @(negedge clk);
    reset = rst; one = c1; two = c2; five = c5;
    #1;
  endtask

  initial begin
    reset = 1'b1; one = 1'b0; two = 1'b0; five = 1'b0;

    // Reset held two cycles with a $1 coin present: the coin is not counted.
    add(1, 1, 0, 0, 0, 0, 0, "rst_hold1");
    add(1, 1, 0, 0, 0, 0, 0, "rst_hold2");
    // Six $1 coins separated by idle cycles.
    add(0, 1, 0, 0, 1, 0, 0, "ones_c1");
    add(0, 0, 0, 0, 1, 0, 0, "ones_i1");
    add(0, 1, 0, 0, 2, 0, 0, "ones_c2");
    add(0, 0, 0, 0, 2, 0, 0, "ones_i2");
    add(0, 1, 0, 0, 3, 0, 0, "ones_c3");
    add(0, 0, 0, 0, 3, 0, 0, "ones_i3");
    add(0, 1, 0, 0, 0, 1, 0, "ones_c4");
    add(0, 0, 0, 0, 0, 0, 0, "ones_i4");
    add(0, 1, 0, 0, 1, 0, 0, "ones_c5");
    add(0, 0, 0, 0, 1, 0, 0, "ones_i5");
    add(0, 1, 0, 0, 2, 0, 0, "ones_c6");
    add(0, 0, 0, 0, 2, 0, 0, "ones_i6");
    // From S2, five $2 coins with idle gaps.
    add(0, 0, 1, 0, 0, 1, 0, "twos_c1");
    add(0, 0, 0, 0, 0, 0, 0, "twos_i1");
    add(0, 0, 1, 0, 2, 0, 0, "twos_c2");
    add(0, 0, 0, 0, 2, 0, 0, "twos_i2");
    add(0, 0, 1, 0, 0, 1, 0, "twos_c3");
    add(0, 0, 0, 0, 0, 0, 0, "twos_i3");
    add(0, 0, 1, 0, 2, 0, 0, "twos_c4");
    add(0, 0, 0, 0, 2, 0, 0, "twos_i4");
    add(0, 0, 1, 0, 0, 1, 0, "twos_c5");
    add(0, 0, 0, 0, 0, 0, 0, "twos_i5");
    // Change ladder, coins on consecutive edges (no dead cycle after dispense).
    add(0, 0, 0, 1, 0, 1, 1, "chg_k0");
    add(0, 1, 0, 0, 1, 0, 0, "chg_k1_1");
    add(0, 0, 0, 1, 0, 1, 2, "chg_k1_5");
    add(0, 1, 0, 0, 1, 0, 0, "chg_k2_1");
    add(0, 1, 0, 0, 2, 0, 0, "chg_k2_2");
    add(0, 0, 0, 1, 0, 1, 3, "chg_k2_5");
    add(0, 1, 0, 0, 1, 0, 0, "chg_k3_1");
    add(0, 1, 0, 0, 2, 0, 0, "chg_k3_2");
    add(0, 1, 0, 0, 3, 0, 0, "chg_k3_3");
    add(0, 0, 0, 1, 0, 1, 4, "chg_k3_5_max");
    add(0, 1, 0, 0, 1, 0, 0, "chg_k4_1");
    add(0, 1, 0, 0, 2, 0, 0, "chg_k4_2");
    add(0, 1, 0, 0, 3, 0, 0, "chg_k4_3");
    add(0, 1, 0, 0, 0, 1, 0, "chg_k4_4");
    add(0, 0, 0, 1, 0, 1, 1, "chg_k4_5");
    add(0, 0, 0, 0, 0, 0, 0, "pulse_drop");
    // Simultaneous coins are ignored; idle holds credit.
    add(0, 1, 0, 0, 1, 0, 0, "multi_s1");
    add(0, 1, 1, 0, 1, 0, 0, "multi_12");
    add(0, 0, 0, 0, 1, 0, 0, "multi_idle");
    add(0, 0, 1, 1, 1, 0, 0, "multi_25");
    add(0, 1, 1, 1, 1, 0, 0, "multi_125");
    add(0, 1, 0, 1, 1, 0, 0, "multi_15");
    // Reset at S3 with a $5 coin wins over the purchase; next coin is normal.
    add(0, 0, 1, 0, 3, 0, 0, "to_s3");
    add(1, 0, 0, 1, 0, 0, 0, "rst_s3_five");
    add(0, 0, 0, 1, 0, 1, 1, "post_rst_five");
    add(0, 0, 0, 0, 0, 0, 0, "post_rst_idle");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].c1, vecs[i].c2, vecs[i].c5);
      chk({vecs[i].tag, "_ns"}, int'(ns), vecs[i].exp_cs);
      @(posedge clk);
      #1;
      chk({vecs[i].tag, "_cs"}, int'(cs), vecs[i].exp_cs);
      chk({vecs[i].tag, "_d"},  int'(d),  vecs[i].exp_d);
      chk({vecs[i].tag, "_r"},  int'(r),  vecs[i].exp_r);
    end

    // Randomized phase against the credit model, starting from a clean reset.
    drive(1, 0, 0, 0);
    @(posedge clk);
    m_credit = 0; m_d = 0; m_r = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rr, a1, a2, a5;
      rr = ($urandom_range(0, 29) == 0);
      a1 = ($urandom_range(0, 2) == 0);
      a2 = ($urandom_range(0, 2) == 0);
      a5 = ($urandom_range(0, 3) == 0);
      drive(rr, a1, a2, a5);
      model_step(rr, a1, a2, a5);
      chk("rand_ns", int'(ns), m_credit);
      @(posedge clk);
      #1;
      chk("rand_cs", int'(cs), m_credit);
      chk("rand_d",  int'(d),  m_d);
      chk("rand_r",  int'(r),  m_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_machine_core.md
VENDING_MACHINE_CORE -- requirements
Module: vending_machine

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state and output registers update on it.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising clk edge.
REQ-004 one  input  1  a $1 coin is present this cycle.
REQ-005 two  input  1  a $2 coin is present this cycle.
REQ-006 five  input  1  a $5 coin is present this cycle.
REQ-007 cs  output  3  current state register (credit held), visible for debug.
REQ-008 ns  output  3  combinational next-state value, visible for debug.
REQ-009 d  output  1  dispense pulse, registered.
REQ-010 r  output  3  change returned in $ units, registered; valid while d=1, otherwise 0.

Function
REQ-011 Item price SHALL be $4.
REQ-012 States SHALL be S0..S3, encoded 3'd0..3'd3, meaning $0..$3 of accumulated credit.
REQ-013 Coin inputs SHALL be level-sampled on each rising edge; each sampled cycle with exactly one coin input high SHALL count as one coin.
REQ-014 No coin high on an edge: state held, d=0, r=0 next cycle.
REQ-015 More than one coin input high on the same edge: the cycle is ignored; state held, d=0, r=0.
REQ-016 Sum = credit(cs) + coin value (1, 2 or 5); if sum < 4 then ns = sum, else ns = S0.
REQ-017 When sum >= 4, on that edge: d SHALL register to 1 and r SHALL register to sum - 4; range 0..4, fits 3 bits.
REQ-018 d and r SHALL be high or non-zero for exactly one cycle per purchase; they return to 0 on the next edge unless another purchase completes on it.
REQ-019 Back-to-back coins on consecutive edges SHALL each be accepted; no dead cycle after a dispense.
REQ-020 ns SHALL be purely combinational from cs, one, two and five, and SHALL show S0 while reset=1.
REQ-021 Illegal cs codes 4..7 SHALL go to S0 on the next edge with d=0, r=0; the coin offered on that edge is discarded.
REQ-022 Maximum change case: S3 + $5 SHALL give d=1, r=4.

Reset
REQ-023 reset=1 on a rising edge SHALL set cs=S0, d=0, r=0, regardless of coin inputs.
REQ-024 Reset SHALL take priority over any coin and over purchase completion on the same edge.
REQ-025 Reset mid-credit (e.g. cs=S3) SHALL discard the credit with no dispense and no change.
REQ-026 After reset deasserts, the first edge with a coin SHALL be accepted normally.

Verification
REQ-027 Reset held 2 cycles with one=1 -> cs=0, d=0, r=0; the coin is not counted.
REQ-028 Six $1 coins (one=1 for 1 cycle, then 0 for 1 cycle, repeated) from S0 -> cs sequence 1,2,3,0,1,2; d=1 with r=0 only after the 4th coin.
REQ-029 From S2, five $2 coins separated by idle cycles -> cs 0,2,0,2,0; d=1 with r=0 after coins 1, 3 and 5.
REQ-030 From S0: $5 -> d=1, r=1. Then k $1 coins followed by $5, for k=1,2,3 -> r=2,3,4 respectively, cs=0 each time. For k=4 -> 4th $1 dispenses with r=0, then $5 gives r=1.
REQ-031 one=1 and two=1 together at S1 -> cs stays 1, d=0; idle cycles hold cs with d=0, r=0.
REQ-032 Reset asserted at S3 together with five=1 -> cs=0, d=0, r=0.
